fft_frame_ctrl: RTL
===================

# fft_frame_ctrl

Frame sequencer in front of the 16-point radix-4 FFT core. Collects a continuous audio sample stream into ping-pong frame banks, launches the FFT on each completed frame, waits for completion and settling, presents the result to the spectrum/display consumer with a valid/ready handshake, then re-arms the core. It sits between the ADC sample interface and `fft_16`. It owns the core's `start` and `rst`.

## Interface
- `WIDTH`, 12, sample width in bits; must match the FFT core's `WIDTH`.
- `N`, 16, frame length in samples; must match the FFT core's `N`.
- `SETTLE`, 2, cycles waited after `fft_done` before results are presented; minimum 1.
- `TIMEOUT`, 15, maximum cycles in RUN before abort; minimum 4.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `sample_in`  in  WIDTH  ADC sample.
- `sample_valid`  in  1  qualifies `sample_in` for one cycle.
- `time_samples`  out  WIDTH x N  processing-bank contents, wired to the FFT core.
- `fft_start`  out  1  one-cycle launch pulse to the core.
- `fft_rst`  out  1  core reset; equals `rst` OR'd with the internal re-arm pulse.
- `fft_done`  in  1  core completion level.
- `result_valid`  out  1  the core's frequency outputs hold a complete frame.
- `result_ready`  in  1  consumer has copied the frame.
- `frame_id`  out  8  count of frames presented; wraps 255 -> 0.
- `overrun`  out  1  sticky; at least one sample was dropped.
- `timeout_err`  out  1  sticky; the core failed to signal done.
- `busy`  out  1  high in every state except IDLE.

## Operation
- There are two banks, each N x WIDTH. One is the fill bank, which is written; the other is the processing bank, which drives `time_samples`.
- Fill: each `sample_valid` writes `sample_in` to fill[`wr_ptr`] and increments `wr_ptr`. Writing index N-1 marks the fill bank full.
- While the fill bank is full, incoming samples are dropped and `overrun` is set. `wr_ptr` holds at N-1.
- Swap: occurs when the fill bank is full and the FSM is in IDLE. The bank roles flip, `wr_ptr` goes to 0, the full flag clears, and the FSM moves to START.
  - If a swap and a `sample_valid` occur in the same cycle, the sample is written to index 0 of the new fill bank and is not dropped.
- FSM states:
  - IDLE: wait for a full fill bank, then swap and go to START.
  - START: `fft_start`=1 for one cycle, then go to RUN.
  - RUN: wait for `fft_done`=1, then go to SETTLE. If `fft_done` has not arrived after TIMEOUT cycles, set `timeout_err` and go to REARM; that frame is discarded and `frame_id` is unchanged.
  - SETTLE: count SETTLE cycles, then go to PRESENT.
  - PRESENT: `result_valid`=1. When `result_ready` is high on a posedge, increment `frame_id` and go to REARM. If `result_ready` is already high on PRESENT entry, that handshake completes on the first PRESENT cycle.
  - REARM: `fft_rst`=1 for one cycle, then go to IDLE.
- Filling continues in every state. Only the processing bank is frozen from swap until REARM exits.
- Arithmetic: `wr_ptr` is $clog2(N) bits wide and `frame_id` is 8 bits; neither saturates.
- Reset mid-operation: any state returns to IDLE on the next posedge.
  - `fft_rst` is high during `rst`.
  - Both banks clear to 0, `wr_ptr`=0, and the full flag clears.

## Timing
- Reset values: `fft_start`=0, `result_valid`=0, `busy`=0, `frame_id`=0, `overrun`=0, `timeout_err`=0, `time_samples` all 0.
- While `rst` is high, `fft_rst`=1. After reset, `fft_rst`=0 except in REARM.
- Swap happens on the posedge that writes sample N-1 if the FSM is in IDLE. `fft_start` is high in the cycle after that edge.
- From `fft_done` first sampled high, `result_valid` rises SETTLE+1 cycles later.
- `result_valid` falls on the posedge that samples `result_ready`. `fft_rst` is high in the following cycle, and `busy` falls one cycle after that.
- The consumer must copy the frequency outputs before REARM, because re-arming clears the core's outputs.
- Minimum frame period with a core taking 3 cycles to done, SETTLE=2 and immediate ready: 9 cycles. Sample rates of 1 per 9 cycles or slower never overrun.
- `time_samples` changes only at a swap or a reset.

## Configuration
- `FFT_CTRL_OFFSET_BIN_EN` defined: `sample_in` is offset-binary ADC data. Its MSB is inverted before the bank write, so 12'h800 is stored as 12'h000 (two's-complement zero).
- `FFT_CTRL_OFFSET_BIN_EN` undefined: `sample_in` is already two's complement and is stored unmodified.

## Test plan
- Reset, then 16 `sample_valid` pulses with values 0..15, one every 20 cycles:
  - `fft_start` pulses once in the cycle after the 16th write.
  - `time_samples[k]`=k.
  - Model `fft_done` 3 cycles after start; `result_valid` rises 3 cycles after done. Hold `result_ready`=1: `frame_id`=1 and `fft_rst` pulses once.
- Continuous `sample_valid` every cycle with `result_ready` held 0:
  - The second bank fills, `overrun` sets, and `wr_ptr` holds at 15.
  - Release ready: an immediate swap and a new `fft_start` follow REARM.
- Tie `fft_done`=0 after start: `timeout_err` sets after 15 RUN cycles, `fft_rst` pulses, the FSM returns to IDLE, and `frame_id` stays 0.
- Assert `rst` for one cycle during PRESENT: next cycle `result_valid`=0, `busy`=0, `fft_rst`=1 during reset, banks read 0, and `frame_id` is cleared to 0.
- Swap and `sample_valid`=1 in the same cycle with value 12'h123: new fill bank index 0 holds 12'h123 and `overrun` stays 0.
- With `FFT_CTRL_OFFSET_BIN_EN`: inputs 12'h800 and 12'hFFF are stored as 12'h000 and 12'h7FF. Without the macro: the same inputs are stored as 12'h800 and 12'hFFF.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame sequencer in front of the 16-point FFT core. Audio samples are
// collected into ping-pong banks. Each completed bank is handed to the core,
// which is then started. After the core signals done and a settling delay,
// the result is presented to the consumer with valid/ready. The core is then
// re-armed through its reset.
//
// Ports
//   clk, rst          clock (posedge) and synchronous active-high reset
//   sample_in_i       ADC sample, qualified by sample_valid_i
//   time_samples_o    processing-bank contents, wired to the FFT core
//   fft_start_o       one-cycle launch pulse to the core
//   fft_rst_o         core reset: rst OR the one-cycle re-arm pulse
//   fft_done_i        core completion level
//   result_valid_o    core outputs hold a complete frame
//   result_ready_i    consumer has copied the frame
//   frame_id_o        count of frames presented (wraps)
//   overrun_o         sticky: at least one sample was dropped
//   timeout_err_o     sticky: the core failed to signal done in time
//   busy_o            high in every state except IDLE
//
// Configuration
//   FFT_CTRL_OFFSET_BIN_EN  when defined, sample_in_i is offset-binary and its
//                           MSB is inverted before storage. When undefined,
//                           samples are stored unmodified.
module fft_frame_ctrl #(
    parameter int WIDTH   = 12,
    parameter int N       = 16,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        sample_in_i,
    input  logic                    sample_valid_i,
    output logic [N-1:0][WIDTH-1:0] time_samples_o,
    output logic                    fft_start_o,
    output logic                    fft_rst_o,
    input  logic                    fft_done_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [7:0]              frame_id_o,
    output logic                    overrun_o,
    output logic                    timeout_err_o,
    output logic                    busy_o
);

    localparam int PTR_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_PRESENT = 3'd4,
        S_REARM   = 3'd5
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0][N-1:0][WIDTH-1:0] bank_q;
    logic                         sel_q, sel_d;      // index of the processing bank
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic                         full_q, full_d;
    logic [7:0]                   frame_id_q, frame_id_d;
    logic                         overrun_q, overrun_d;
    logic                         timeout_q, timeout_d;

    logic                         swap;
    logic                         wr_en;
    logic                         wr_bank;
    logic [PTR_W-1:0]             wr_idx;
    logic [WIDTH-1:0]             wr_data;
    logic                         drop;
    logic                         run_expired;

`ifdef FFT_CTRL_OFFSET_BIN_EN
    // Offset-binary to two's complement: mid-scale 0x800 becomes zero.
    assign wr_data = {~sample_in_i[WIDTH-1], sample_in_i[WIDTH-2:0]};
`else
    assign wr_data = sample_in_i;
`endif

    assign run_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Fill-side datapath and swap decision.
    // Two swap cases exist in IDLE:
    //  - The bank is already full (it filled while the core was busy). Any
    //    sample in this cycle lands at index 0 of the bank that becomes the
    //    new fill bank, and the pointer moves past it.
    //  - This cycle writes the last index. The sample completes the old fill
    //    bank, and that bank swaps in on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        swap     = 1'b0;
        wr_en    = 1'b0;
        wr_bank  = ~sel_q;
        wr_idx   = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        sel_d    = sel_q;
        drop     = 1'b0;
        if (state_q == S_IDLE && full_q) begin
            swap     = 1'b1;
            sel_d    = ~sel_q;
            full_d   = 1'b0;
            wr_bank  = sel_q;
            wr_idx   = '0;
            wr_en    = sample_valid_i;
            wr_ptr_d = sample_valid_i ? PTR_W'(1) : '0;
        end else if (sample_valid_i) begin
            if (full_q) begin
                drop = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_ptr_q == LAST_IDX) begin
                    if (state_q == S_IDLE) begin
                        swap     = 1'b1;
                        sel_d    = ~sel_q;
                        wr_ptr_d = '0;
                    end else begin
                        // Hold at the last index until the swap.
                        full_d = 1'b1;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (swap) state_d = S_START;
            S_START:   state_d = S_RUN;
            S_RUN: begin
                if (fft_done_i)       state_d = S_SETTLE;
                else if (run_expired) state_d = S_REARM;
            end
            S_SETTLE:  if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_PRESENT;
            S_PRESENT: if (result_ready_i) state_d = S_REARM;
            S_REARM:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        fft_start_o    = (state_q == S_START);
        result_valid_o = (state_q == S_PRESENT);
        busy_o         = (state_q != S_IDLE);
        fft_rst_o      = rst | (state_q == S_REARM);
    end

    // Cycle counter: counts cycles spent in RUN and SETTLE, and restarts
    // at zero on every state change.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_RUN || state_q == S_SETTLE) && state_d == state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Status: a timed-out frame is discarded and is not counted.
    always_comb begin
        frame_id_d = frame_id_q;
        if (state_q == S_PRESENT && result_ready_i) begin
            frame_id_d = frame_id_q + 8'd1;
        end
        overrun_d = overrun_q | drop;
        timeout_d = timeout_q | (state_q == S_RUN && !fft_done_i && run_expired);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q     <= '0;
            sel_q      <= 1'b0;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
            cnt_q      <= '0;
            frame_id_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                bank_q[wr_bank][wr_idx] <= wr_data;
            end
            sel_q      <= sel_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            cnt_q      <= cnt_d;
            frame_id_q <= frame_id_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    // The processing bank is frozen from the swap until the next swap.
    assign time_samples_o = bank_q[sel_q];
    assign frame_id_o     = frame_id_q;
    assign overrun_o      = overrun_q;
    assign timeout_err_o  = timeout_q;

endmodule
